fifo_rd_packer: RTL and testbench

//  - Read-side consumer for fifo_async; lives entirely in the read clock domain.
//  - Pops DW-bit entries whenever the FIFO is not empty.
//  - Packs BEATS consecutive entries into one DW*BEATS-bit word; first popped entry goes in the LSBs.
//  - Presents each word on a valid/ready output port to downstream logic, e.g. a bus-width upsizer.

---
 rtl/fifo_rd_packer.sv | 170 +++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-side consumer for fifo_async. All logic is in the read clock domain.
// The block pops DW-bit entries whenever the FIFO is not empty and packs BEATS
// consecutive entries into one DW*BEATS-bit word. The first popped entry goes
// in the LSBs. Each word is presented on a valid/ready port, for example to a
// bus-width upsizer.
//
// Optional feature: define RD_PACK_FLUSH_EN to add the flush input and the
// out_keep output. With it, a partially filled word can be emitted early.
//
// Parameters
//   DW     width of one FIFO entry (must match fifo_async DW)
//   BEATS  entries per output word, >= 2
//
// Ports
//   r_clk        in   1         read-domain clock, posedge
//   r_rst        in   1         asynchronous active-high reset
//   fifo_empty   in   1         fifo_async empty flag
//   fifo_r_en    out  1         pop strobe to fifo_async
//   fifo_r_data  in   DW        fifo_async registered read data (1-cycle latency)
//   out_valid    out  1         packed word available
//   out_ready    in   1         downstream accepts word
//   out_data     out  DW*BEATS  packed word, first entry in the LSBs
//   flush        in   1         [RD_PACK_FLUSH_EN] emit the partial word
//   out_keep     out  BEATS     [RD_PACK_FLUSH_EN] per-entry valid mask
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
  parameter int DW    = 8,
  parameter int BEATS = 4
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic                fifo_empty,
  output logic                fifo_r_en,
  input  logic [DW-1:0]       fifo_r_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW*BEATS-1:0] out_data
`ifdef RD_PACK_FLUSH_EN
  ,
  input  logic                flush,
  output logic [BEATS-1:0]    out_keep
`endif
);

  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_OUT  = 1'b1;

  logic [0:0]          state;
  logic [CW-1:0]       issued;     // pops requested for the current word
  logic [CW-1:0]       captured;   // entries written into the pack buffer
  logic [CW-1:0]       cap_next;
  logic                rd_pend;    // a pop was issued last cycle; its data is on fifo_r_data now
  logic [DW*BEATS-1:0] pack_q;
  logic [DW*BEATS-1:0] pack_next;
  logic                word_full;
  logic                flush_req;
  logic                flush_done;
  logic                to_out;
  logic                handshake;

  // Merge the data arriving this cycle into the pack buffer.
  // NOTE: every signal written here is given a default value first. Without
  // this, a path that skips an assignment would infer a latch.
  always_comb begin
    pack_next = pack_q;
    cap_next  = captured;
    if (rd_pend) begin
      for (int i = 0; i < BEATS; i++) begin
        if (captured == CW'(i)) pack_next[i*DW +: DW] = fifo_r_data;
      end
      cap_next = captured + CW'(1);
    end
  end

`ifdef RD_PACK_FLUSH_EN
  logic             flush_pend;
  logic [BEATS-1:0] keep_next;

  // A flush is honoured only if something has been popped. It then stays
  // pending until the in-flight read has landed.
  assign flush_req  = (state == ST_FILL) && (flush_pend || (flush && (issued != '0)));
  assign flush_done = flush_req && !rd_pend;

  always_comb begin
    keep_next = '0;
    for (int i = 0; i < BEATS; i++) begin
      keep_next[i] = (CW'(i) < cap_next);
    end
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      flush_pend <= 1'b0;
      out_keep   <= '0;
    end else begin
      flush_pend <= flush_req && !to_out;
      if (to_out) out_keep <= keep_next;
    end
  end
`else
  assign flush_req  = 1'b0;
  assign flush_done = 1'b0;
`endif

  assign word_full = (state == ST_FILL) && (cap_next == BEATS_C);
  assign to_out    = word_full || flush_done;
  assign handshake = (state == ST_OUT) && out_valid && out_ready;

  // Pops are gated while r_rst is held. Any entry popped during reset would
  // be dropped, because rd_pend is forced low.
  assign fifo_r_en = !r_rst && (state == ST_FILL) && !fifo_empty &&
                     (issued < BEATS_C) && !flush_req;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples pre-edge values. Blocking assignments here would create
  // order-dependent simulation races.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      state     <= ST_FILL;
      issued    <= '0;
      captured  <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      // NOTE: the pack buffer is reset on purpose, not left as plain storage.
      // A flushed partial word relies on its unfilled slots being zero.
      pack_q    <= '0;
    end else begin
      rd_pend <= fifo_r_en;
      case (state)
        ST_FILL: begin
          if (fifo_r_en) issued <= issued + CW'(1);
          captured <= cap_next;
          if (to_out) begin
            state     <= ST_OUT;
            out_valid <= 1'b1;
            out_data  <= pack_next;
            pack_q    <= '0;
          end else begin
            pack_q <= pack_next;
          end
        end
        ST_OUT: begin
          if (handshake) begin
            state     <= ST_FILL;
            out_valid <= 1'b0;
            issued    <= '0;
            captured  <= '0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  // Structural invariants of the pop/capture pipeline and the output port.
  a_no_underflow : assert property (@(posedge r_clk) disable iff (r_rst)
    !(fifo_r_en && fifo_empty));
  a_capture_trails : assert property (@(posedge r_clk) disable iff (r_rst)
    (captured <= issued) && ((issued - captured) <= CW'(1)));
  a_out_stable : assert property (@(posedge r_clk) disable iff (r_rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//
// Directed bench for fifo_rd_packer. A small FIFO model feeds the DUT, with
// one cycle of registered read latency. Stimulus pushes the hand-computed
// expected words into a scoreboard queue. A monitor process pops and compares
// a word whenever a valid&&ready handshake occurs. The monitor also watches
// for pops while the FIFO is empty and for output changes while stalled.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

  localparam int DW    = 8;
  localparam int BEATS = 4;

  typedef struct {
    logic [DW*BEATS-1:0] data;
`ifdef RD_PACK_FLUSH_EN
    logic [BEATS-1:0]    keep;
`endif
  } exp_t;

  logic                r_clk = 1'b0;
  logic                r_rst = 1'b1;
  logic                fifo_empty;
  logic                fifo_r_en;
  logic [DW-1:0]       fifo_r_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [DW*BEATS-1:0] out_data;
`ifdef RD_PACK_FLUSH_EN
  logic                flush = 1'b0;
  logic [BEATS-1:0]    out_keep;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rx  = 0;
  exp_t exp_q[$];

  fifo_rd_packer #(.DW(DW), .BEATS(BEATS)) dut (
    .r_clk       (r_clk),
    .r_rst       (r_rst),
    .fifo_empty  (fifo_empty),
    .fifo_r_en   (fifo_r_en),
    .fifo_r_data (fifo_r_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef RD_PACK_FLUSH_EN
    ,
    .flush       (flush),
    .out_keep    (out_keep)
`endif
  );

  always #5 r_clk = ~r_clk;

  // FIFO model. Stimulus writes at posedge+1; reads are registered on posedge.
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge r_clk) begin
    if (fifo_r_en) begin
      fifo_r_data <= mem[rd_ptr % 64];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [DW*BEATS-1:0] d, input logic [BEATS-1:0] k);
    exp_t e;
    e.data = d;
`ifdef RD_PACK_FLUSH_EN
    e.keep = k;
`else
    if (k == '0) e.data = d;  // mask only exists with the flush feature
`endif
    exp_q.push_back(e);
  endtask

  // Wait until the monitor has seen n words in total. Expiry counts as a failure.
  task automatic wait_words(input int n, input int budget);
    int cyc = 0;
    while (n_rx < n && cyc < budget) begin
      tick(1);
      cyc++;
    end
    if (n_rx < n) check("word_timeout", 64'(n_rx), 64'(n));
  endtask

  // Monitor / scoreboard.
  logic                hold_v = 1'b0;
  logic [DW*BEATS-1:0] hold_d = '0;

  always @(negedge r_clk) begin
    if (r_rst) begin
      hold_v = 1'b0;
    end else begin
      if (fifo_empty) check("no_pop_when_empty", 64'(fifo_r_en), 64'(0));
      if (hold_v) begin
        check("stall_data_stable", 64'(out_data), 64'(hold_d));
        check("stall_valid_held", 64'(out_valid), 64'(1));
      end
      if (out_valid) check("no_pop_in_out", 64'(fifo_r_en), 64'(0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_data), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", 64'(out_data), 64'(e.data));
`ifdef RD_PACK_FLUSH_EN
          check("word_keep", 64'(out_keep), 64'(e.keep));
`endif
        end
        n_rx++;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  initial begin
    // Reset state.
    tick(3);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_fifo_r_en", 64'(fifo_r_en), 64'(0));
    r_rst = 1'b0;
    tick(2);

    // T1: four entries, out_ready high; valid lasts exactly one cycle.
    expect_word(32'h67666564, 4'hF);
    for (int i = 0; i < 4; i++) push(8'(100 + i));
    wait_words(1, 30);
    check("t1_valid_one_cycle", 64'(out_valid), 64'(0));

    // T2: eight entries with out_ready low for 10 cycles.
    out_ready = 1'b0;
    expect_word(32'h6B6A6968, 4'hF);
    expect_word(32'h6F6E6D6C, 4'hF);
    for (int i = 0; i < 8; i++) push(8'(104 + i));
    begin
      int cyc = 0;
      while (!out_valid && cyc < 30) begin
        tick(1);
        cyc++;
      end
      check("t2_first_valid", 64'(out_valid), 64'(1));
    end
    tick(10);
    check("t2_no_pops_while_held", 64'(rd_ptr), 64'(8));
    out_ready = 1'b1;
    wait_words(3, 40);

    // T3: FIFO empties after two entries; pops pause and resume 20 cycles later.
    expect_word(32'h44332211, 4'hF);
    push(8'h11);
    push(8'h22);
    tick(20);
    check("t3_no_partial_emit", 64'(n_rx), 64'(3));
    push(8'h33);
    push(8'h44);
    wait_words(4, 30);

    // T4: reset after three captured entries drops the partial word.
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    tick(6);
    #2;
    r_rst = 1'b1;
    #1;
    check("t4_rst_out_valid", 64'(out_valid), 64'(0));
    check("t4_rst_out_data", 64'(out_data), 64'(0));
    check("t4_rst_fifo_r_en", 64'(fifo_r_en), 64'(0));
    tick(2);
    r_rst = 1'b0;
    tick(1);
    expect_word(32'hB4B3B2B1, 4'hF);
    for (int i = 0; i < 4; i++) push(8'(8'hB1 + i));
    wait_words(5, 30);

`ifdef RD_PACK_FLUSH_EN
    // T5: flush after two captured entries emits a partial word.
    expect_word(32'h0000BBAA, 4'b0011);
    push(8'hAA);
    push(8'hBB);
    tick(5);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_words(6, 20);

    // T6: flush while empty and idle does nothing.
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(10);
    check("t6_idle_flush_ignored", 64'(n_rx), 64'(6));
    check("t6_no_valid", 64'(out_valid), 64'(0));
`endif

    tick(2);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
